// File: rtl/montgomery_pkg.sv
// Shared types and constants for the Montgomery modular-exponentiation sequencer.
package montgomery_pkg;

  // Sequencer operation states. IDLE and FINISH issue no multiplication.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CONV_X   = 3'd1,
    CONV_ONE = 3'd2,
    SQR      = 3'd3,
    MUL      = 3'd4,
    CONV_OUT = 3'd5,
    FINISH   = 3'd6
  } state_t;

  // Every operation state first issues one core request, then waits for its result.
  typedef enum logic {
    ISSUE = 1'b0,
    WAIT  = 1'b1
  } phase_t;

  // Multiplications per exponentiation:
  //   MM_FIXED_OPS + e_size + popcount(exponent[e_size-1:0])
  // The fixed part is CONV_X, CONV_ONE and CONV_OUT.
  localparam int unsigned MM_FIXED_OPS = 3;

endpackage

// File: rtl/modexp_exp_scanner.sv
// Left-to-right exponent bit scanner: holds the latched exponent and the current
// bit index, and reports the current bit and whether it is the last one.
module modexp_exp_scanner
  import montgomery_pkg::*;
#(
  parameter int EBITS = 2048
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [EBITS-1:0] i_exponent,
  input  logic [11:0]      i_e_size,
  output logic             o_bit,
  output logic             o_last,
  output logic             o_zero
);

  localparam logic [11:0] EBITS_W = 12'(EBITS);

  logic [EBITS-1:0] r_exp;
  logic [11:0]      r_idx;
  logic             r_zero;
  logic [11:0]      w_e_eff;
  logic [EBITS-1:0] w_shifted;

  // An e_size beyond the register width is clamped, so scanning never starts
  // above the top exponent bit; bits at e_size and above are never visited.
  assign w_e_eff = (i_e_size > EBITS_W) ? EBITS_W : i_e_size;

  // Latch the exponent on load; walk the index down one bit per step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exp  <= '0;
      r_idx  <= '0;
      r_zero <= 1'b1;
    end else if (i_load) begin
      r_exp  <= i_exponent;
      r_idx  <= w_e_eff - 12'd1;
      r_zero <= (w_e_eff == 12'd0);
    end else if (i_step && (r_idx != 12'd0)) begin
      r_idx <= r_idx - 12'd1;
    end
  end

  // A shift avoids a width-mismatched variable bit select.
  assign w_shifted = r_exp >> r_idx;
  assign o_bit     = w_shifted[0];
  assign o_last    = (r_idx == 12'd0);
  assign o_zero    = r_zero;

endmodule

// File: rtl/montgomery_modexp_ctrl.sv
// Sequencer computing y = base^exponent mod m through one external Montgomery
// multiplier core, using left-to-right square-and-multiply.
//
// Core handshake: o_mm_enable_p is high for exactly one cycle (the ISSUE phase)
// with o_mm_a/o_mm_b already valid. The operands stay stable through the whole
// WAIT phase until the core returns i_mm_done_p with the result on i_mm_y,
// which is sampled in that same cycle. i_mm_done_p outside WAIT is ignored.
module montgomery_modexp_ctrl
  import montgomery_pkg::*;
#(
  parameter int NBITS = 2048,
  parameter int EBITS = 2048
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start_p,
  input  logic [NBITS-1:0] i_base,
  input  logic [NBITS-1:0] i_modulus,
  input  logic [NBITS-1:0] i_r2,
  input  logic [11:0]      i_m_size,
  input  logic [EBITS-1:0] i_exponent,
  input  logic [11:0]      i_e_size,
  output logic             o_busy,
  output logic [NBITS-1:0] o_y,
  output logic             o_done_irq_p,
  output logic             o_mm_enable_p,
  output logic [NBITS-1:0] o_mm_a,
  output logic [NBITS-1:0] o_mm_b,
  output logic [NBITS-1:0] o_mm_m,
  output logic [11:0]      o_mm_m_size,
  input  logic [NBITS-1:0] i_mm_y,
  input  logic             i_mm_done_p,
  output logic [2:0]       o_dbg_state,
  output logic             o_dbg_phase
);

  localparam logic [NBITS-1:0] ONE = NBITS'(1);

  state_t r_state, w_state_nx, w_op_next;
  phase_t r_phase, w_phase_nx;

  logic [NBITS-1:0] r_xb;
  logic [NBITS-1:0] r_r2;
  logic [NBITS-1:0] r_y;
  logic [NBITS-1:0] r_mm_a;
  logic [NBITS-1:0] r_mm_b;
  logic [NBITS-1:0] r_mm_m;
  logic [11:0]      r_mm_m_size;

  logic w_load;
  logic w_op_done;
  logic w_step;
  logic w_bit;
  logic w_last;
  logic w_zero;

  assign w_load    = (r_state == IDLE) && i_start_p;
  assign w_op_done = (r_phase == WAIT) && i_mm_done_p &&
                     (r_state != IDLE) && (r_state != FINISH);

  // The index moves down only when the decision step chooses another square.
  assign w_step = w_op_done && !w_last &&
                  (((r_state == SQR) && !w_bit) || (r_state == MUL));

  modexp_exp_scanner #(
    .EBITS(EBITS)
  ) u_scanner (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_exponent (i_exponent),
    .i_e_size   (i_e_size),
    .o_bit      (w_bit),
    .o_last     (w_last),
    .o_zero     (w_zero)
  );

  // State register: operation state plus its ISSUE/WAIT phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_phase <= ISSUE;
    end else begin
      r_state <= w_state_nx;
      r_phase <= w_phase_nx;
    end
  end

  // Operation that follows the current one once its result arrives.
  always_comb begin
    w_op_next = r_state;
    unique case (r_state)
      CONV_X:   w_op_next = CONV_ONE;
      CONV_ONE: w_op_next = w_zero ? CONV_OUT : SQR;
      SQR:      w_op_next = w_bit ? MUL : (w_last ? CONV_OUT : SQR);
      MUL:      w_op_next = w_last ? CONV_OUT : SQR;
      CONV_OUT: w_op_next = FINISH;
      default:  w_op_next = r_state;
    endcase
  end

  // Next-state logic: ISSUE always lasts one cycle, WAIT lasts until the core answers.
  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    unique case (r_state)
      IDLE: begin
        if (i_start_p) begin
          w_state_nx = CONV_X;
          w_phase_nx = ISSUE;
        end
      end
      FINISH: begin
        w_state_nx = IDLE;
        w_phase_nx = ISSUE;
      end
      default: begin
        if (r_phase == ISSUE) begin
          w_phase_nx = WAIT;
        end else if (i_mm_done_p) begin
          w_state_nx = w_op_next;
          w_phase_nx = ISSUE;
        end
      end
    endcase
  end

  // Output decode from state and phase.
  always_comb begin
    o_busy        = (r_state != IDLE);
    o_done_irq_p  = (r_state == FINISH);
    o_mm_enable_p = (r_phase == ISSUE) && (r_state != IDLE) && (r_state != FINISH);
  end

  // Datapath: latch operands on start, capture core results, and preload the
  // next operands straight from i_mm_y so the next request can go out at once.
  // The running accumulator lives in r_mm_a between operations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xb        <= '0;
      r_r2        <= '0;
      r_y         <= '0;
      r_mm_a      <= '0;
      r_mm_b      <= '0;
      r_mm_m      <= '0;
      r_mm_m_size <= '0;
    end else if (w_load) begin
      r_r2        <= i_r2;
      r_mm_a      <= i_base;
      r_mm_b      <= i_r2;
      r_mm_m      <= i_modulus;
      r_mm_m_size <= i_m_size;
    end else if (w_op_done) begin
      if (r_state == CONV_X)   r_xb <= i_mm_y;
      if (r_state == CONV_OUT) r_y  <= i_mm_y;
      unique case (w_op_next)
        CONV_ONE: begin
          r_mm_a <= r_r2;
          r_mm_b <= ONE;
        end
        SQR: begin
          r_mm_a <= i_mm_y;
          r_mm_b <= i_mm_y;
        end
        MUL: begin
          r_mm_a <= i_mm_y;
          r_mm_b <= r_xb;
        end
        CONV_OUT: begin
          r_mm_a <= i_mm_y;
          r_mm_b <= ONE;
        end
        default: begin
          r_mm_a <= r_mm_a;
          r_mm_b <= r_mm_b;
        end
      endcase
    end
  end

  assign o_y         = r_y;
  assign o_mm_a      = r_mm_a;
  assign o_mm_b      = r_mm_b;
  assign o_mm_m      = r_mm_m;
  assign o_mm_m_size = r_mm_m_size;
  assign o_dbg_state = r_state;
  assign o_dbg_phase = r_phase;

endmodule
